// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 64-bit memory port between the instruction-fetch
// and data-access ports of the pipeline. Each access runs IDLE -> ISSUE -> WAIT.
// In ISSUE, mem_cs is high for one cycle. WAIT ends on mem_ready or on a bus timeout.
// Arbitration gives fixed priority to data, and a starvation counter lets
// imem win after STARVE_LIMIT consecutive losses.
// Define MEM_ARB_RR_EN to use round-robin arbitration between the two ports instead.
module mem_arbiter #(
   parameter int ADDR_W         = 64,
   parameter int DATA_W         = 64,
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ack,
   output logic              i_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              d_err,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

   state_t            state, state_nxt;
   logic              owner_d;     // 1 = current access belongs to the data port
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [TW-1:0]     tcnt;
   logic              any_req;
   logic              grant_d;
   logic              timeout_hit;

`ifdef MEM_ARB_RR_EN
   logic              rr_last_i;   // 1 = imem was served most recently

   // Round-robin choice: when both request, the port not served last wins
   always_comb begin
      any_req = i_req | d_req;
      grant_d = d_req & (~i_req | rr_last_i);
   end

   // Pointer tracks the port granted most recently
   always_ff @(posedge clk) begin
      if (rst)
         rr_last_i <= 1'b1;
      else if (state == IDLE && any_req)
         rr_last_i <= ~grant_d;
   end
`else
   logic [3:0]        starve_cnt;

   // Fixed data priority, overridden once imem has lost STARVE_LIMIT times in a row
   always_comb begin
      any_req = i_req | d_req;
      grant_d = d_req & (~i_req | (starve_cnt != 4'(STARVE_LIMIT)));
   end

   // Count imem losses; clear when imem wins or is not asking
   always_ff @(posedge clk) begin
      if (rst)
         starve_cnt <= '0;
      else if (state == IDLE) begin
         if (!i_req || !grant_d)
            starve_cnt <= '0;
         else if (starve_cnt != 4'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 4'd1;
      end
   end
`endif

   assign timeout_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));

   // Next-state logic for the access sequencer
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (mem_ready || timeout_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Capture the winner's request at grant; it is not re-sampled mid-access
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_d   <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (state == IDLE && any_req) begin
         owner_d  <= grant_d;
         lat_we   <= grant_d & d_we;
         lat_addr <= grant_d ? d_addr : i_addr;
         if (grant_d)
            lat_wdata <= d_wdata;
      end
   end

   // Count WAIT cycles without mem_ready; restarted on every issue
   always_ff @(posedge clk) begin
      if (rst)
         tcnt <= '0;
      else if (state == ISSUE)
         tcnt <= '0;
      else if (state == WAIT && !mem_ready && !timeout_hit)
         tcnt <= tcnt + TW'(1);
   end

   // Completion: one-cycle ack/err pulses and read data returned to the owner
   always_ff @(posedge clk) begin
      if (rst) begin
         i_ack   <= 1'b0;
         i_err   <= 1'b0;
         d_ack   <= 1'b0;
         d_err   <= 1'b0;
         i_rdata <= '0;
         d_rdata <= '0;
      end else begin
         i_ack <= 1'b0;
         i_err <= 1'b0;
         d_ack <= 1'b0;
         d_err <= 1'b0;
         if (state == WAIT) begin
            if (mem_ready) begin
               if (owner_d) begin
                  d_ack <= 1'b1;
                  if (!lat_we)
                     d_rdata <= mem_rdata;
               end else begin
                  i_ack   <= 1'b1;
                  i_rdata <= mem_rdata;
               end
            end else if (timeout_hit) begin
               if (owner_d) begin
                  d_ack   <= 1'b1;
                  d_err   <= 1'b1;
                  d_rdata <= '0;
               end else begin
                  i_ack   <= 1'b1;
                  i_err   <= 1'b1;
                  i_rdata <= '0;
               end
            end
         end
      end
   end

   // Memory port: select only in ISSUE, address/data held from the latch
   always_comb begin
      mem_cs    = (state == ISSUE);
      mem_we    = (state == ISSUE) & lat_we;
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
   end

endmodule
